// File: rtl/pkt_stream_monitor.sv
// Frame delineation and checking for the upstream byte stream, with
// per-frame length/checksum capture and good/bad counters on a 16-bit register bus.
module pkt_stream_monitor #(
  parameter logic [15:0] BASE_ADDR = 16'h0010,
  parameter int          MIN_LEN   = 60,
  parameter int          MAX_LEN   = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_cmd_valid,
  input  logic        bus_op,
  input  logic [15:0] bus_addr,
  input  logic [15:0] bus_wr_data,
  output logic [15:0] bus_rd_data,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  output logic        frame_done,
  output logic        frame_err
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, PRE, BODY, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic        in_run_reg;
  logic        enable_reg, enable_next;
  logic [15:0] len_reg, csum_reg;
  logic [15:0] good_cnt_reg, good_cnt_next;
  logic [15:0] bad_cnt_reg, bad_cnt_next;
  logic [15:0] last_len_reg, last_csum_reg;
  logic [1:0]  err_code_reg;
  logic [15:0] bus_rd_data_reg;
  logic        frame_done_reg, frame_err_reg;

  logic        frame_end, body_start, body_byte, clear;
  logic [1:0]  end_code;
  logic [15:0] offset, rd_mux;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state; a start is only recognised on the first byte of an rx_dv run,
  // so a run already in flight when enabled (or across reset) is skipped whole.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (enable_reg && rx_dv && !in_run_reg) begin
          if (rxd == 8'h55)      state_next = PRE;
          else if (rxd == 8'hD5) state_next = BODY;
          else                   state_next = DRAIN;
        end
      end
      PRE: begin
        if (!rx_dv)             state_next = IDLE;
        else if (rxd == 8'h55)  state_next = PRE;
        else if (rxd == 8'hD5)  state_next = BODY;
        else                    state_next = DRAIN;
      end
      BODY:    if (!rx_dv) state_next = IDLE;
      DRAIN:   if (!rx_dv) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM-derived strobes
  always_comb begin
    frame_end  = (state_reg != IDLE) && !rx_dv;
    body_start = (state_next == BODY) && (state_reg != BODY);
    body_byte  = (state_reg == BODY) && rx_dv;
    end_code   = 2'd1;
    if (state_reg == BODY) begin
      if (len_reg < MIN_L)      end_code = 2'd2;
      else if (len_reg > MAX_L) end_code = 2'd3;
      else                      end_code = 2'd0;
    end
  end

  // Bus decode and register file next values
  always_comb begin
    offset        = bus_addr - BASE_ADDR;
    clear         = 1'b0;
    enable_next   = enable_reg;
    if (bus_cmd_valid && bus_op && (offset == 16'd0)) begin
      enable_next = bus_wr_data[0];
      clear       = bus_wr_data[1];
    end

    good_cnt_next = good_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    if (frame_end && (end_code == 2'd0) && (good_cnt_reg != 16'hFFFF))
      good_cnt_next = good_cnt_reg + 16'd1;
    if (frame_end && (end_code != 2'd0) && (bad_cnt_reg != 16'hFFFF))
      bad_cnt_next = bad_cnt_reg + 16'd1;
    if (clear) begin
      good_cnt_next = 16'd0;
      bad_cnt_next  = 16'd0;
    end

    case (offset)
      16'd0:   rd_mux = {15'd0, enable_reg};
      16'd1:   rd_mux = good_cnt_reg;
      16'd2:   rd_mux = bad_cnt_reg;
      16'd3:   rd_mux = last_len_reg;
      16'd4:   rd_mux = last_csum_reg;
      16'd5:   rd_mux = {13'd0, err_code_reg, (state_reg != IDLE)};
      default: rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_run_reg      <= rx_dv;
      enable_reg      <= 1'b1;
      len_reg         <= 16'd0;
      csum_reg        <= 16'd0;
      good_cnt_reg    <= 16'd0;
      bad_cnt_reg     <= 16'd0;
      last_len_reg    <= 16'd0;
      last_csum_reg   <= 16'd0;
      err_code_reg    <= 2'd0;
      bus_rd_data_reg <= 16'd0;
      frame_done_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      in_run_reg   <= rx_dv;
      enable_reg   <= enable_next;
      good_cnt_reg <= good_cnt_next;
      bad_cnt_reg  <= bad_cnt_next;

      if (body_start) begin
        len_reg  <= 16'd0;
        csum_reg <= 16'd0;
      end else if (body_byte) begin
        if (len_reg != 16'hFFFF) len_reg <= len_reg + 16'd1;
        csum_reg <= csum_reg + {8'd0, rxd};
      end

      // Preamble/SFD failures never reached the body, so they report zero length/checksum
      if (frame_end) begin
        last_len_reg  <= (end_code == 2'd1) ? 16'd0 : len_reg;
        last_csum_reg <= (end_code == 2'd1) ? 16'd0 : csum_reg;
        err_code_reg  <= end_code;
      end

      frame_done_reg <= frame_end && (end_code == 2'd0);
      frame_err_reg  <= frame_end && (end_code != 2'd0);

      if (bus_cmd_valid && !bus_op) bus_rd_data_reg <= rd_mux;
    end
  end

  assign bus_rd_data = bus_rd_data_reg;
  assign frame_done  = frame_done_reg;
  assign frame_err   = frame_err_reg;

endmodule
